// File: rtl/x_dl_edge_stats.sv
// Delay-line calibration statistics: per-run first-edge hit/miss counts, min, max and sum
// of edge positions over P_SAMPLES snapshots, returned as one valid/ready record.
`timescale 1ns/1ps
module x_dl_edge_stats #(
    parameter  int unsigned P_LENGTH  = 256,
    parameter  int unsigned P_SAMPLES = 1024,
    localparam int unsigned P_IDX_W   = $clog2(P_LENGTH),
    localparam int unsigned P_CNT_W   = $clog2(P_SAMPLES + 1),
    localparam int unsigned P_SUM_W   = P_IDX_W + P_CNT_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [P_LENGTH-1:0] i_data,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic                i_abort,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_valid,
    output logic [P_CNT_W-1:0]  o_hits,
    output logic [P_CNT_W-1:0]  o_miss,
    output logic [P_IDX_W-1:0]  o_min,
    output logic [P_IDX_W-1:0]  o_max,
    output logic [P_SUM_W-1:0]  o_sum
);

    localparam logic [P_CNT_W-1:0] RUN_LAST = P_CNT_W'(P_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [1:0]           mode_q;
    logic [P_CNT_W-1:0]   run_cnt;
    logic                 drain_cnt;

    logic                 s1_vld;
    logic [P_LENGTH-1:0]  s1_data;
    logic                 s2_vld;
    logic                 s2_hit;
    logic [P_IDX_W-1:0]   s2_idx;

    logic [P_LENGTH-2:0]  edge_vec;
    logic                 want_rise;
    logic                 want_fall;
    logic                 enc_hit;
    logic [P_IDX_W-1:0]   enc_idx;
    logic                 start_run;

    assign start_run = (state == S_IDLE) && i_start;
    assign want_rise = (mode_q == 2'd1);
    assign want_fall = (mode_q == 2'd2);

    // Candidate edge at k: neighbours differ and the upper tap matches the requested polarity.
    for (genvar k = 0; k < P_LENGTH - 1; k++) begin : g_edge
        assign edge_vec[k] = (s1_data[k] ^ s1_data[k+1])
                           & ~(want_rise & ~s1_data[k+1])
                           & ~(want_fall &  s1_data[k+1]);
    end

    // Lowest-index priority encoder.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int unsigned k = 0; k < P_LENGTH - 1; k++) begin
            if (!enc_hit && edge_vec[k]) begin
                enc_hit = 1'b1;
                enc_idx = P_IDX_W'(k);
            end
        end
    end

    // Run control: RUN for P_SAMPLES cycles, two drain cycles, then hold the record.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            run_cnt   <= '0;
            drain_cnt <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
        end else if (i_abort) begin
            state     <= S_IDLE;
            mode_q    <= 2'd0;
            run_cnt   <= '0;
            drain_cnt <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state   <= S_RUN;
                        mode_q  <= i_mode;
                        run_cnt <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt + P_CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state   <= S_DONE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture and encode stages; the valid token marks snapshots belonging to the run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s2_vld  <= 1'b0;
            s2_hit  <= 1'b0;
            s2_idx  <= '0;
        end else begin
            s1_vld  <= (state == S_RUN) && !i_abort;
            s1_data <= i_data;
            s2_vld  <= s1_vld && !i_abort;
            s2_hit  <= enc_hit;
            s2_idx  <= enc_idx;
        end
    end

    // Accumulators double as the output record and hold it after the handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hits <= '0;
            o_miss <= '0;
            o_min  <= '1;
            o_max  <= '0;
            o_sum  <= '0;
        end else if (i_abort || start_run) begin
            o_hits <= '0;
            o_miss <= '0;
            o_min  <= '1;
            o_max  <= '0;
            o_sum  <= '0;
        end else if (s2_vld) begin
            if (s2_hit) begin
                o_hits <= o_hits + P_CNT_W'(1);
                o_sum  <= o_sum + P_SUM_W'(s2_idx);
                if (s2_idx < o_min) o_min <= s2_idx;
                if (s2_idx > o_max) o_max <= s2_idx;
            end else begin
                o_miss <= o_miss + P_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_x_dl_edge_stats.sv
// Bench for x_dl_edge_stats: a small instance checked every cycle against a timeline model,
// plus a full-size instance checked on a long randomised run.
`timescale 1ns/1ps
module tb_x_dl_edge_stats;

    localparam int S_LEN = 16;
    localparam int S_N   = 4;
    localparam int S_IW  = $clog2(S_LEN);
    localparam int S_CW  = $clog2(S_N + 1);
    localparam int S_SW  = S_IW + S_CW;
    localparam int B_LEN = 256;
    localparam int B_N   = 1024;
    localparam int B_IW  = $clog2(B_LEN);
    localparam int B_CW  = $clog2(B_N + 1);
    localparam int B_SW  = B_IW + B_CW;

    typedef struct packed {
        int hits;
        int miss;
        int mn;
        int mx;
        int sum;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S_LEN-1:0] s_data  = '0;
    logic             s_start = 1'b0;
    logic [1:0]       s_mode  = 2'd0;
    logic             s_abort = 1'b0;
    logic             s_ready = 1'b0;
    logic             s_busy, s_valid;
    logic [S_CW-1:0]  s_hits, s_miss;
    logic [S_IW-1:0]  s_min, s_max;
    logic [S_SW-1:0]  s_sum;

    logic [B_LEN-1:0] b_data  = '0;
    logic             b_start = 1'b0;
    logic [1:0]       b_mode  = 2'd0;
    logic             b_abort = 1'b0;
    logic             b_ready = 1'b0;
    logic             b_busy, b_valid;
    logic [B_CW-1:0]  b_hits, b_miss;
    logic [B_IW-1:0]  b_min, b_max;
    logic [B_SW-1:0]  b_sum;

    x_dl_edge_stats #(.P_LENGTH(S_LEN), .P_SAMPLES(S_N)) u_small (
        .i_clk(clk), .i_rst(rst), .i_data(s_data), .i_start(s_start), .i_mode(s_mode),
        .i_abort(s_abort), .i_ready(s_ready), .o_busy(s_busy), .o_valid(s_valid),
        .o_hits(s_hits), .o_miss(s_miss), .o_min(s_min), .o_max(s_max), .o_sum(s_sum)
    );

    x_dl_edge_stats #(.P_LENGTH(B_LEN), .P_SAMPLES(B_N)) u_big (
        .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_start(b_start), .i_mode(b_mode),
        .i_abort(b_abort), .i_ready(b_ready), .o_busy(b_busy), .o_valid(b_valid),
        .o_hits(b_hits), .o_miss(b_miss), .o_min(b_min), .o_max(b_max), .o_sum(b_sum)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // First k with data[k] != data[k+1] and the requested polarity on data[k+1]; -1 if none.
    function automatic int edge_of(input logic [B_LEN-1:0] d, input int len, input logic [1:0] mode);
        for (int k = 0; k < len - 1; k++) begin
            if (d[k] != d[k+1] && (mode != 2'd1 || d[k+1]) && (mode != 2'd2 || !d[k+1]))
                return k;
        end
        return -1;
    endfunction

    function automatic rec_t rst_rec(input int mn);
        return '{hits: 0, miss: 0, mn: mn, mx: 0, sum: 0};
    endfunction

    function automatic rec_t acc(input rec_t r, input int e);
        rec_t n = r;
        if (e < 0) n.miss++;
        else begin
            n.hits++;
            n.sum += e;
            if (e < n.mn) n.mn = e;
            if (e > n.mx) n.mx = e;
        end
        return n;
    endfunction

    // Timeline model of the small instance: edges counted from the accepted start.
    int         m_k = -1;
    bit         m_busy = 1'b0;
    bit         m_valid = 1'b0;
    logic [1:0] m_mode = 2'd0;
    rec_t       m_acc;
    rec_t       m_rec;

    always @(posedge clk) begin
        if (rst || s_abort) begin
            m_k = -1; m_busy = 1'b0; m_valid = 1'b0; m_rec = rst_rec(S_LEN - 1);
        end else if (m_valid) begin
            if (s_ready) begin m_valid = 1'b0; m_k = -1; end
        end else if (m_k < 0) begin
            if (s_start) begin
                m_k = 0; m_busy = 1'b1; m_mode = s_mode;
                m_acc = rst_rec(S_LEN - 1); m_rec = rst_rec(S_LEN - 1);
            end
        end else begin
            m_k++;
            if (m_k <= S_N) m_acc = acc(m_acc, edge_of(B_LEN'(s_data), S_LEN, m_mode));
            if (m_k == S_N + 2) begin m_busy = 1'b0; m_valid = 1'b1; m_rec = m_acc; end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", longint'(s_busy), longint'(m_busy));
        chk("valid", longint'(s_valid), longint'(m_valid));
        if (!m_busy) begin
            chk("hits", longint'(s_hits), longint'(m_rec.hits));
            chk("miss", longint'(s_miss), longint'(m_rec.miss));
            chk("min", longint'(s_min), longint'(m_rec.mn));
            chk("max", longint'(s_max), longint'(m_rec.mx));
            chk("sum", longint'(s_sum), longint'(m_rec.sum));
        end
        if (m_valid) chk("hits_plus_miss", longint'(s_hits) + longint'(s_miss), longint'(S_N));
    end

    logic [S_LEN-1:0] snaps [S_N];

    function automatic logic [S_LEN-1:0] gen16();
        int unsigned p = $urandom_range(1, S_LEN - 1);
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            1:       return 16'((32'd1 << p) - 32'd1);
            2:       return ~16'((32'd1 << p) - 32'd1);
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [B_LEN-1:0] gen256();
        logic [B_LEN-1:0] d = '0;
        int unsigned p = $urandom_range(1, B_LEN - 1);
        case ($urandom_range(0, 3))
            0: d = ($urandom_range(0, 1) != 0) ? '1 : '0;
            1: for (int i = 0; i < B_LEN; i++) d[i] = (i < int'(p));
            2: for (int i = 0; i < B_LEN; i++) d[i] = (i >= int'(p));
            default: for (int w = 0; w < B_LEN / 32; w++) d[w*32 +: 32] = $urandom;
        endcase
        return d;
    endfunction

    // One run on the small instance; abort_at>0 aborts on that cycle, noise pulses i_start.
    task automatic run_small(input logic [1:0] mode, input int hold, input int abort_at,
                             input bit noise, input bit use_lit, input rec_t lit);
        int waited = 0;
        bit got = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = mode;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            s_abort = 1'b0;
            s_ready = 1'b0;
            s_mode  = 2'($urandom);
            s_data  = (c <= S_N) ? snaps[c-1] : 16'($urandom);
            if (abort_at > 0) begin
                if (c == abort_at) s_abort = 1'b1;
                if (c == abort_at + 12) return;
                continue;
            end
            if (noise) s_start = 1'($urandom);
            if (!got && s_valid) begin
                got = 1'b1;
                chk("latency", c, S_N + 3);
                if (use_lit) begin
                    chk("lit_hits", longint'(s_hits), longint'(lit.hits));
                    chk("lit_miss", longint'(s_miss), longint'(lit.miss));
                    chk("lit_min", longint'(s_min), longint'(lit.mn));
                    chk("lit_max", longint'(s_max), longint'(lit.mx));
                    chk("lit_sum", longint'(s_sum), longint'(lit.sum));
                end
            end
            if (got) begin
                if (waited > hold) begin
                    s_start = 1'b0;
                    return;
                end
                if (waited == hold) s_ready = 1'b1;
                waited++;
            end
        end
        chk("run_timeout", 0, 1);
        s_start = 1'b0;
    endtask

    task automatic big_run();
        rec_t       exp = rst_rec(B_LEN - 1);
        logic [1:0] bm = 2'($urandom);
        bit         got = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = bm;
        for (int c = 1; c <= B_N + 20 && !got; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_mode  = 2'($urandom);
            if (c <= B_N) begin
                b_data = gen256();
                exp = acc(exp, edge_of(b_data, B_LEN, bm));
            end
            chk("big_busy", longint'(b_busy), longint'(c <= B_N + 2));
            if (b_valid) begin
                got = 1'b1;
                chk("big_latency", c, B_N + 3);
                chk("big_hits", longint'(b_hits), longint'(exp.hits));
                chk("big_miss", longint'(b_miss), longint'(exp.miss));
                chk("big_min", longint'(b_min), longint'(exp.mn));
                chk("big_max", longint'(b_max), longint'(exp.mx));
                chk("big_sum", longint'(b_sum), longint'(exp.sum));
                b_ready = 1'b1;
            end
        end
        if (!got) chk("big_timeout", 0, 1);
        @(negedge clk);
        b_ready = 1'b0;
        chk("big_valid_drop", longint'(b_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        chk("pin_any", edge_of(256'h00FF, S_LEN, 2'd0), 7);
        chk("pin_rise", edge_of(256'h00F0, S_LEN, 2'd1), 3);
        chk("pin_fall", edge_of(256'h00F0, S_LEN, 2'd2), 7);
        chk("pin_miss", edge_of(256'hFFFF, S_LEN, 2'd3), -1);
        chk("pin_top_rise", edge_of(256'h8000, S_LEN, 2'd1), 14);
        chk("pin_top_fall", edge_of(256'h7FFF, S_LEN, 2'd1), -1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Constant pattern, then the staircase pattern with one miss.
        for (int i = 0; i < S_N; i++) snaps[i] = 16'h00FF;
        run_small(2'd0, 0, 0, 1'b0, 1'b1, '{hits: 4, miss: 0, mn: 7, mx: 7, sum: 28});
        snaps[0] = 16'h000F; snaps[1] = 16'h00FF; snaps[2] = 16'h0FFF; snaps[3] = 16'hFFFF;
        run_small(2'd0, 0, 0, 1'b0, 1'b1, '{hits: 3, miss: 1, mn: 3, mx: 11, sum: 21});

        // Polarity selection.
        for (int i = 0; i < S_N; i++) snaps[i] = 16'h00F0;
        run_small(2'd1, 1, 0, 1'b0, 1'b1, '{hits: 4, miss: 0, mn: 3, mx: 3, sum: 12});
        run_small(2'd2, 1, 0, 1'b0, 1'b1, '{hits: 4, miss: 0, mn: 7, mx: 7, sum: 28});
        for (int i = 0; i < S_N; i++) snaps[i] = 16'hFFFF;
        run_small(2'd3, 0, 0, 1'b0, 1'b1, '{hits: 0, miss: 4, mn: 15, mx: 0, sum: 0});

        // Backpressure with start pulses.
        for (int i = 0; i < S_N; i++) snaps[i] = 16'h00FF;
        run_small(2'd0, 10, 0, 1'b1, 1'b1, '{hits: 4, miss: 0, mn: 7, mx: 7, sum: 28});

        // Abort early in RUN, then a normal run.
        run_small(2'd0, 0, 2, 1'b0, 1'b0, rst_rec(S_LEN - 1));
        snaps[0] = 16'h000F; snaps[1] = 16'h00FF; snaps[2] = 16'h0FFF; snaps[3] = 16'hFFFF;
        run_small(2'd0, 0, 0, 1'b0, 1'b1, '{hits: 3, miss: 1, mn: 3, mx: 11, sum: 21});

        // Reset in the middle of a run.
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = 2'd0;
        repeat (5) begin
            @(negedge clk);
            s_start = 1'b0;
            s_data  = 16'h00FF;
        end
        rst = 1'b1;
        #1;
        chk("rst_valid", longint'(s_valid), 0);
        chk("rst_busy", longint'(s_busy), 0);
        chk("rst_min", longint'(s_min), 15);
        chk("rst_hits", longint'(s_hits), 0);
        chk("rst_sum", longint'(s_sum), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Randomised runs against the model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < S_N; i++) snaps[i] = gen16();
            run_small(2'($urandom), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0,
                      1'($urandom), 1'b0, rst_rec(S_LEN - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        big_run();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
